// File: rtl/fetch_queue.sv
// Instruction-fetch stage: drives the PC, reads instruction memory asynchronously and
// buffers {nextpc, instruction} pairs in a small FIFO so that decode stalls do not stop fetch.
module fetch_queue #(
  parameter int              XLEN       = 32,
  parameter int              AW         = 7,
  parameter int              DEPTH      = 4,
  parameter int              PC_STEP    = 1,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'('h40)
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic [AW-1:0]              imem_addr,
  input  logic [XLEN-1:0]            imem_rdata,
  input  logic                       is_if_stall,
  input  logic                       id_if_selpcsource,
  input  logic [1:0]                 id_if_selpctype,
  input  logic [XLEN-1:0]            id_if_pcimd2ext,
  input  logic [XLEN-1:0]            id_if_rega,
  input  logic [XLEN-1:0]            id_if_pcindex,
  output logic                       if_id_valid,
  output logic [XLEN-1:0]            if_id_instruc,
  output logic [XLEN-1:0]            if_id_nextpc,
  output logic [$clog2(DEPTH+1)-1:0] if_queue_count
);

  localparam int              PW   = $clog2(DEPTH);
  localparam int              CW   = $clog2(DEPTH+1);
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);

  logic [XLEN-1:0] pc_reg, pc_next, pc_plus, redirect_pc;
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next, wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]   count_reg, count_next;
  logic            redirect, empty, pop, push;

  logic [XLEN-1:0] instr_mem  [DEPTH];
  logic [XLEN-1:0] nextpc_mem [DEPTH];

  assign redirect = id_if_selpcsource;
  assign empty    = (count_reg == '0);
  // A redirect flushes the queue, so it suppresses both the pop and the push of that cycle.
  assign pop      = !redirect && !empty && !is_if_stall;
  assign push     = !redirect && ((count_reg != FULL) || pop);
  assign pc_plus  = pc_reg + STEP;

  always_comb begin
    redirect_pc = id_if_pcimd2ext;
    case (id_if_selpctype)
      2'b00: redirect_pc = id_if_pcimd2ext;
      2'b01: redirect_pc = id_if_rega;
      2'b10: redirect_pc = id_if_pcindex;
      2'b11: redirect_pc = EXC_VECTOR;
    endcase
  end

  always_comb begin
    pc_next     = pc_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (redirect) begin
      pc_next     = redirect_pc;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        pc_next     = pc_plus;
        wr_ptr_next = wr_ptr_reg + PW'(1);
      end
      if (pop) rd_ptr_next = rd_ptr_reg + PW'(1);
      count_next = count_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_reg     <= RESET_PC;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      pc_reg     <= pc_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage needs no reset: entries are only visible while counted as occupied.
  always_ff @(posedge clock) begin
    if (reset && push) begin
      instr_mem[wr_ptr_reg]  <= imem_rdata;
      nextpc_mem[wr_ptr_reg] <= pc_plus;
    end
  end

  assign imem_addr      = pc_reg[AW-1:0];
  assign if_id_valid    = !empty;
  assign if_id_instruc  = empty ? '0 : instr_mem[rd_ptr_reg];
  assign if_id_nextpc   = empty ? '0 : nextpc_mem[rd_ptr_reg];
  assign if_queue_count = count_reg;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_fetch_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        is_if_stall = 1'b0;
  logic        id_if_selpcsource = 1'b0;
  logic [1:0]  id_if_selpctype = 2'b00;
  logic [31:0] id_if_pcimd2ext = '0, id_if_rega = '0, id_if_pcindex = '0;
  logic        if_id_valid;
  logic [31:0] if_id_instruc, if_id_nextpc;
  logic [2:0]  if_queue_count;

  // 8-bit instance for PC wrap-around
  logic [6:0]  imem_addr8;
  logic [7:0]  imem_rdata8;
  logic        stall8 = 1'b0, redirect8 = 1'b0;
  logic [1:0]  type8 = 2'b00;
  logic [7:0]  tgt8 = '0;
  logic        valid8;
  logic [7:0]  instr8, nextpc8;
  logic [2:0]  count8;

  logic [31:0] mem [128];
  int checks = 0;
  int errors = 0;

  // model state: queue of {nextpc, instr} and the fetch PC
  logic [63:0] m_q[$];
  logic [31:0] m_pc = '0;

  always #5 clock = ~clock;

  assign imem_rdata  = mem[imem_addr];
  assign imem_rdata8 = {1'b0, imem_addr8};

  fetch_queue dut (
    .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .is_if_stall(is_if_stall), .id_if_selpcsource(id_if_selpcsource),
    .id_if_selpctype(id_if_selpctype), .id_if_pcimd2ext(id_if_pcimd2ext),
    .id_if_rega(id_if_rega), .id_if_pcindex(id_if_pcindex),
    .if_id_valid(if_id_valid), .if_id_instruc(if_id_instruc),
    .if_id_nextpc(if_id_nextpc), .if_queue_count(if_queue_count)
  );

  fetch_queue #(.XLEN(8), .AW(7), .DEPTH(4), .PC_STEP(1), .RESET_PC(8'hFE)) dut8 (
    .clock(clock), .reset(reset), .imem_addr(imem_addr8), .imem_rdata(imem_rdata8),
    .is_if_stall(stall8), .id_if_selpcsource(redirect8), .id_if_selpctype(type8),
    .id_if_pcimd2ext(tgt8), .id_if_rega(tgt8), .id_if_pcindex(tgt8),
    .if_id_valid(valid8), .if_id_instruc(instr8), .if_id_nextpc(nextpc8),
    .if_queue_count(count8)
  );

  // Model advances one clock using the inputs held across the edge.
  task automatic model_tick();
    if (!reset) begin
      m_pc = '0;
      m_q.delete();
    end else if (id_if_selpcsource) begin
      m_q.delete();
      case (id_if_selpctype)
        2'b00: m_pc = id_if_pcimd2ext;
        2'b01: m_pc = id_if_rega;
        2'b10: m_pc = id_if_pcindex;
        default: m_pc = 32'h40;
      endcase
    end else begin
      if (m_q.size() > 0 && !is_if_stall) void'(m_q.pop_front());
      if (m_q.size() < 4) begin
        m_q.push_back({m_pc + 32'd1, mem[m_pc[6:0]]});
        m_pc = m_pc + 32'd1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_tick();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    id_if_selpcsource = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    is_if_stall = 1'b0;
    do_reset();
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", if_id_valid); end
    checks++; if (if_id_instruc !== 32'h0) begin errors++; $display("FAIL reset_instruc got %h want 0", if_id_instruc); end
    checks++; if (if_id_nextpc !== 32'h0) begin errors++; $display("FAIL reset_nextpc got %h want 0", if_id_nextpc); end
    checks++; if (if_queue_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", if_queue_count); end
    checks++; if (imem_addr !== 7'd0) begin errors++; $display("FAIL reset_addr got %h want 0", imem_addr); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0b want 1", i, if_id_valid); end
      checks++; if (if_id_instruc !== 32'h1000 + i) begin errors++; $display("FAIL stream_instruc[%0d] got %h want %h", i, if_id_instruc, 32'h1000 + i); end
      checks++; if (if_id_nextpc !== 32'(i + 1)) begin errors++; $display("FAIL stream_nextpc[%0d] got %h want %h", i, if_id_nextpc, i + 1); end
      checks++; if (if_queue_count !== 3'd1) begin errors++; $display("FAIL stream_count[%0d] got %0d want 1", i, if_queue_count); end
    end
  endtask

  task automatic test_stall_and_full_pop();
    do_reset();
    is_if_stall = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++; if (if_queue_count !== 3'(k < 4 ? k : 4)) begin errors++; $display("FAIL stall_count[%0d] got %0d want %0d", k, if_queue_count, (k < 4 ? k : 4)); end
      checks++; if (imem_addr !== 7'(k < 4 ? k : 4)) begin errors++; $display("FAIL stall_addr[%0d] got %0d want %0d", k, imem_addr, (k < 4 ? k : 4)); end
    end
    is_if_stall = 1'b0;
    // full queue popped every cycle: one push per cycle, strictly sequential heads
    for (int j = 0; j < 12; j++) begin
      checks++; if (if_id_instruc !== 32'h1000 + j) begin errors++; $display("FAIL fullpop_instruc[%0d] got %h want %h", j, if_id_instruc, 32'h1000 + j); end
      checks++; if (if_id_nextpc !== 32'(j + 1)) begin errors++; $display("FAIL fullpop_nextpc[%0d] got %h want %h", j, if_id_nextpc, j + 1); end
      checks++; if (if_queue_count !== 3'd4) begin errors++; $display("FAIL fullpop_count[%0d] got %0d want 4", j, if_queue_count); end
      tick();
    end
  endtask

  task automatic test_redirect();
    logic [1:0]  types [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
    logic [31:0] want;
    for (int t = 0; t < 4; t++) begin
      do_reset();
      is_if_stall = 1'b1;
      repeat (3) tick();
      id_if_selpcsource = 1'b1;
      id_if_selpctype = types[t];
      id_if_rega = 32'h20; id_if_pcimd2ext = 32'h30; id_if_pcindex = 32'h50;
      want = (types[t] == 2'b01) ? 32'h20 : (types[t] == 2'b00) ? 32'h30 :
             (types[t] == 2'b10) ? 32'h50 : 32'h40;
      tick();
      id_if_selpcsource = 1'b0;
      checks++; if (if_queue_count !== 3'd0) begin errors++; $display("FAIL redir_count[%0d] got %0d want 0", t, if_queue_count); end
      checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL redir_valid[%0d] got %0b want 0", t, if_id_valid); end
      checks++; if (imem_addr !== want[6:0]) begin errors++; $display("FAIL redir_addr[%0d] got %h want %h", t, imem_addr, want[6:0]); end
      tick();
      checks++; if (if_id_instruc !== 32'h1000 + want) begin errors++; $display("FAIL redir_instruc[%0d] got %h want %h", t, if_id_instruc, 32'h1000 + want); end
      checks++; if (if_id_nextpc !== want + 1) begin errors++; $display("FAIL redir_nextpc[%0d] got %h want %h", t, if_id_nextpc, want + 1); end
    end
    is_if_stall = 1'b0;
  endtask

  task automatic test_redirect_with_pop();
    do_reset();
    is_if_stall = 1'b1;
    repeat (2) tick();
    is_if_stall = 1'b0;
    id_if_selpcsource = 1'b1; id_if_selpctype = 2'b00; id_if_pcimd2ext = 32'h10;
    tick();
    id_if_selpcsource = 1'b0;
    checks++; if (if_queue_count !== 3'd0) begin errors++; $display("FAIL rpop_count got %0d want 0", if_queue_count); end
    checks++; if (if_id_instruc !== 32'h0) begin errors++; $display("FAIL rpop_instruc got %h want 0", if_id_instruc); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (if_id_instruc !== 32'h1010 + i) begin errors++; $display("FAIL rpop_head[%0d] got %h want %h", i, if_id_instruc, 32'h1010 + i); end
      checks++; if (if_queue_count !== 3'd1) begin errors++; $display("FAIL rpop_after_count[%0d] got %0d want 1", i, if_queue_count); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] want_np [3] = '{8'hFF, 8'h00, 8'h01};
    logic [7:0] want_in [3] = '{8'h7E, 8'h7F, 8'h00};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (nextpc8 !== want_np[i]) begin errors++; $display("FAIL wrap_nextpc[%0d] got %h want %h", i, nextpc8, want_np[i]); end
      checks++; if (instr8 !== want_in[i]) begin errors++; $display("FAIL wrap_instr[%0d] got %h want %h", i, instr8, want_in[i]); end
    end
  endtask

  task automatic test_reset_mid();
    is_if_stall = 1'b1;
    repeat (6) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    is_if_stall = 1'b0;
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %0b want 0", if_id_valid); end
    checks++; if (if_queue_count !== 3'd0) begin errors++; $display("FAIL midrst_count got %0d want 0", if_queue_count); end
    checks++; if (imem_addr !== 7'd0) begin errors++; $display("FAIL midrst_addr got %h want 0", imem_addr); end
    tick();
    checks++; if (if_id_instruc !== 32'h1000) begin errors++; $display("FAIL midrst_head got %h want 1000", if_id_instruc); end
    checks++; if (if_id_nextpc !== 32'h1) begin errors++; $display("FAIL midrst_nextpc got %h want 1", if_id_nextpc); end
  endtask

  task automatic test_random();
    logic        e_valid;
    logic [31:0] e_instr, e_np;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(99) != 0);
      is_if_stall = ($urandom_range(1) == 1);
      id_if_selpcsource = ($urandom_range(9) == 0);
      id_if_selpctype = 2'($urandom_range(3));
      id_if_pcimd2ext = $urandom; id_if_rega = $urandom; id_if_pcindex = $urandom;
      tick();
      e_valid = (m_q.size() != 0);
      e_instr = e_valid ? m_q[0][31:0] : 32'h0;
      e_np    = e_valid ? m_q[0][63:32] : 32'h0;
      checks++; if (if_id_valid !== e_valid) begin errors++; $display("FAIL rand_valid[%0d] got %0b want %0b", n, if_id_valid, e_valid); end
      checks++; if (if_id_instruc !== e_instr) begin errors++; $display("FAIL rand_instruc[%0d] got %h want %h", n, if_id_instruc, e_instr); end
      checks++; if (if_id_nextpc !== e_np) begin errors++; $display("FAIL rand_nextpc[%0d] got %h want %h", n, if_id_nextpc, e_np); end
      checks++; if (if_queue_count !== 3'(m_q.size())) begin errors++; $display("FAIL rand_count[%0d] got %0d want %0d", n, if_queue_count, m_q.size()); end
      checks++; if (imem_addr !== m_pc[6:0]) begin errors++; $display("FAIL rand_addr[%0d] got %h want %h", n, imem_addr, m_pc[6:0]); end
    end
    reset = 1'b1;
    id_if_selpcsource = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000 + i;
    test_reset();
    test_stream();
    test_stall_and_full_pop();
    test_redirect();
    test_redirect_with_pop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
